// File: rtl/sccomp_pkg.sv
// sccomp_pkg: shared definitions for the sccomp single-cycle RV32I-subset core.
//   - RV32I major opcode constants used by the decoder
//   - ALU operation and immediate-format enumerations
//   - helpers: funct3/funct7 -> ALU op, instruction -> sign-extended immediate
package sccomp_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // alt selects sub/sra; callers only pass it where funct7[5] is meaningful.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'h000};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rf_regfile.sv
// rf_regfile: 32 x 32-bit integer register file.
//   clk_i, rst_ni      : clock, asynchronous active-low reset (clears all registers)
//   ra1_i/rd1_o        : combinational read port 1
//   ra2_i/rd2_o        : combinational read port 2
//   we_i, wa_i, wd_i   : write port, committed on the rising edge; writes to x0 are dropped
module rf_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] rf [0:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      rf[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : rf[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : rf[ra2_i];

endmodule

// File: rtl/sccomp_dm.sv
// sccomp_dm: 128-word data RAM, not reset.
//   clk_i          : clock
//   we_i           : write enable, committed on the rising edge
//   addr_i         : word address
//   wdata_i        : write data
//   rdata_o        : combinational read data
module sccomp_dm (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [6:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] dmem [0:127];

  always_ff @(posedge clk_i) begin
    if (we_i) dmem[addr_i] <= wdata_i;
  end

  assign rdata_o = dmem[addr_i];

endmodule

// File: rtl/sccomp_im.sv
// sccomp_im: 256-word instruction ROM, contents loaded externally by the bench.
//   addr_i : word address (PC[9:2])
//   data_o : combinational read data
module sccomp_im (
  input  logic [7:0]  addr_i,
  output logic [31:0] data_o
);

  logic [31:0] ROM [0:255];

  assign data_o = ROM[addr_i];

endmodule

// File: rtl/sccomp_scpu.sv
// sccomp_scpu: single-cycle RV32I-subset core (decode, ALU, next-PC inline).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   instr_i       : instruction at pc_o
//   pc_o          : program counter
//   dm_rdata_i    : data memory read data
//   dm_we_o       : data memory write enable
//   dm_addr_o     : data memory word address (alu_result[8:2])
//   dm_wdata_o    : data memory write data (rs2)
module sccomp_scpu
  import sccomp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  input  logic [31:0] dm_rdata_i,
  output logic        dm_we_o,
  output logic [6:0]  dm_addr_o,
  output logic [31:0] dm_wdata_o
);

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;

  imm_fmt_e    imm_fmt;
  alu_op_e     alu_op;
  logic        a_pc, a_zero, b_imm;
  logic        rf_we, mem_we, is_load, is_branch, is_jal, is_jalr, halt;

  logic [31:0] imm, rs1_val, rs2_val, alu_a, alu_b, alu_res, wb_data, pc_plus4;
  logic        br_taken;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  always_comb begin
    imm_fmt   = IMM_I;
    alu_op    = ALU_ADD;
    a_pc      = 1'b0;
    a_zero    = 1'b0;
    b_imm     = 1'b0;
    rf_we     = 1'b0;
    mem_we    = 1'b0;
    is_load   = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    halt      = 1'b0;
    case (opcode)
      OPC_OP: begin
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          rf_we  = 1'b1;
          alu_op = alu_decode(funct3, funct7[5]);
        end
      end
      OPC_OP_IMM: begin
        // Only shifts carry funct7; a set imm[10] on addi must not turn it into sub.
        if (!((funct3 == 3'b001) && (funct7 != 7'b0000000)) &&
            !((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))) begin
          rf_we  = 1'b1;
          b_imm  = 1'b1;
          alu_op = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          rf_we   = 1'b1;
          is_load = 1'b1;
          b_imm   = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          mem_we  = 1'b1;
          imm_fmt = IMM_S;
          b_imm   = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
          is_branch = 1'b1;
          imm_fmt   = IMM_B;
        end
      end
      OPC_LUI: begin
        rf_we   = 1'b1;
        imm_fmt = IMM_U;
        a_zero  = 1'b1;
        b_imm   = 1'b1;
      end
      OPC_AUIPC: begin
        rf_we   = 1'b1;
        imm_fmt = IMM_U;
        a_pc    = 1'b1;
        b_imm   = 1'b1;
      end
      OPC_JAL: begin
        rf_we   = 1'b1;
        is_jal  = 1'b1;
        imm_fmt = IMM_J;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rf_we   = 1'b1;
          is_jalr = 1'b1;
          b_imm   = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        halt = (instr_i == INSTR_ECALL);
      end
      default: ;
    endcase
  end

  assign imm   = imm_gen(instr_i, imm_fmt);
  assign alu_a = a_zero ? '0 : (a_pc ? pc_q : rs1_val);
  assign alu_b = b_imm ? imm : rs2_val;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SLL:  alu_res = alu_a << alu_b[4:0];
      ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_res = $signed(alu_a) >>> alu_b[4:0];
      ALU_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'd0, alu_a < alu_b};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;

  // ecall keeps PC on itself, so the halt persists with no extra state until reset.
  always_comb begin
    pc_d = pc_plus4;
    if (halt)                                pc_d = pc_q;
    else if (is_jal || (is_branch && br_taken)) pc_d = pc_q + imm;
    else if (is_jalr)                        pc_d = {alu_res[31:1], 1'b0};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  assign wb_data = (is_jal || is_jalr) ? pc_plus4 : (is_load ? dm_rdata_i : alu_res);

  rf_regfile U_RF (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ra1_i  (rs1),
    .ra2_i  (rs2),
    .rd1_o  (rs1_val),
    .rd2_o  (rs2_val),
    .we_i   (rf_we),
    .wa_i   (rd),
    .wd_i   (wb_data)
  );

  // The RAM has no reset, so a store on an edge that coincides with reset is blocked here.
  assign dm_we_o    = mem_we & rst_ni;
  assign dm_addr_o  = alu_res[8:2];
  assign dm_wdata_o = rs2_val;
  assign pc_o       = pc_q;

endmodule

// File: rtl/sccomp.sv
// sccomp: single-cycle RV32I-subset computer (core + instruction ROM + data RAM).
//   clk  : system clock, all state updates on the rising edge
//   rstn : asynchronous active-low reset
// PC and instr are exposed as top-level signals for the bench.
module sccomp (
  input logic clk,
  input logic rstn
);

  logic [31:0] PC;
  logic [31:0] instr;
  logic        dm_we;
  logic [6:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        unused_pc_bits;

  sccomp_scpu U_SCPU (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .instr_i    (instr),
    .pc_o       (PC),
    .dm_rdata_i (dm_rdata),
    .dm_we_o    (dm_we),
    .dm_addr_o  (dm_addr),
    .dm_wdata_o (dm_wdata)
  );

  // PC bits above the ROM size wrap; the byte offset is ignored.
  sccomp_im U_IM (
    .addr_i (PC[9:2]),
    .data_o (instr)
  );

  assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

  sccomp_dm U_DM (
    .clk_i   (clk),
    .we_i    (dm_we),
    .addr_i  (dm_addr),
    .wdata_i (dm_wdata),
    .rdata_o (dm_rdata)
  );

endmodule

// File: tb/tb_sccomp.sv
module tb_sccomp;

  localparam int OPI = 32'h13;

  logic clk;
  logic rstn;

  sccomp dut (
    .clk  (clk),
    .rstn (rstn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cur_prog;

  logic [31:0] img [0:255];

  // kind: 0 = rf[idx] == val, 1 = dmem[idx] == val, 2 = instr == img[idx], 3 = PC only
  typedef struct {
    int          prog;
    logic [31:0] pc;
    int          kind;
    int          idx;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] a, b, c, d, e;
    a = f7; b = rs2; c = rs1; d = f3; e = rd;
    return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] im, c, d, e, o;
    im = imm; c = rs1; d = f3; e = rd; o = op;
    return {im[11:0], c[4:0], d[2:0], e[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] im, b, c;
    im = imm; b = rs2; c = rs1;
    return {im[11:5], b[4:0], c[4:0], 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, b, c, d;
    im = imm; b = rs2; c = rs1; d = f3;
    return {im[12], im[10:5], b[4:0], c[4:0], d[2:0], im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    logic [31:0] im, e, o;
    im = imm20; e = rd; o = op;
    return {im[19:0], e[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] im, e;
    im = imm; e = rd;
    return {im[20], im[10:1], im[11], im[19:12], e[4:0], 7'h6F};
  endfunction

  task automatic build_img(input int id);
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
    case (id)
      1: begin
        img[0]  = enc_i(5, 0, 0, 1, OPI);
        img[1]  = enc_i(-3, 0, 0, 2, OPI);
        img[2]  = enc_r(0, 2, 1, 0, 3);          // add x3,x1,x2
        img[3]  = enc_r(32, 1, 2, 0, 4);         // sub x4,x2,x1
        img[4]  = enc_r(32, 1, 4, 5, 5);         // sra x5,x4,x1
        img[5]  = enc_r(0, 1, 4, 5, 6);          // srl x6,x4,x1
        img[6]  = enc_s(8, 3, 0);                // sw x3,8(x0)
        img[7]  = enc_i(8, 0, 2, 7, 32'h03);     // lw x7,8(x0)
        img[8]  = enc_j(12, 1);                  // jal x1,+12
        img[9]  = enc_i(1, 0, 0, 10, OPI);
        img[10] = enc_i(2, 0, 0, 10, OPI);
        img[11] = enc_u(32'h12345, 8, 32'h37);   // lui
        img[12] = enc_u(1, 9, 32'h17);           // auipc
        img[13] = enc_i(7, 0, 0, 0, OPI);        // addi x0,x0,7
        img[14] = enc_i(-1, 0, 0, 11, OPI);
        img[15] = enc_i(32'hF0, 11, 4, 12, OPI); // xori
        img[16] = 32'h0000_0073;
      end
      2: begin
        img[0]  = enc_i(5, 0, 0, 1, OPI);
        img[1]  = enc_i(-3, 0, 0, 2, OPI);
        img[2]  = enc_b(8, 1, 1, 0);             // beq x1,x1
        img[3]  = enc_i(1, 0, 0, 13, OPI);
        img[4]  = enc_b(8, 1, 2, 4);             // blt x2,x1
        img[5]  = enc_i(2, 0, 0, 13, OPI);
        img[6]  = enc_b(8, 1, 2, 6);             // bltu x2,x1
        img[7]  = enc_i(3, 0, 0, 14, OPI);
        img[8]  = enc_b(8, 1, 1, 1);             // bne x1,x1
        img[9]  = enc_b(8, 1, 2, 5);             // bge x2,x1
        img[10] = enc_b(8, 1, 2, 7);             // bgeu x2,x1
        img[11] = enc_i(4, 0, 0, 13, OPI);
        img[12] = enc_i(32'h3C, 1, 0, 15, 32'h67); // jalr x15,60(x1)
        img[16] = 32'h0000_0073;
      end
      3: begin
        img[0] = 32'hFFFF_FFFF;                  // unsupported encoding
        img[1] = enc_j(32'h3FC, 5);
      end
      default: begin
        img[0]  = enc_i(5, 0, 0, 1, OPI);
        img[1]  = enc_i(-3, 0, 0, 2, OPI);
        img[2]  = enc_r(0, 2, 1, 7, 3);          // and
        img[3]  = enc_r(0, 2, 1, 6, 4);          // or
        img[4]  = enc_r(0, 2, 1, 4, 5);          // xor
        img[5]  = enc_r(0, 1, 2, 2, 6);          // slt x6,x2,x1
        img[6]  = enc_r(0, 1, 2, 3, 7);          // sltu x7,x2,x1
        img[7]  = enc_r(0, 1, 1, 1, 8);          // sll x8,x1,x1
        img[8]  = enc_i(-2, 2, 2, 9, OPI);       // slti
        img[9]  = enc_i(-1, 1, 3, 10, OPI);      // sltiu
        img[10] = enc_i(32'hF0, 2, 7, 11, OPI);  // andi
        img[11] = enc_i(-16, 1, 6, 12, OPI);     // ori
        img[12] = enc_i(28, 1, 1, 13, OPI);      // slli
        img[13] = enc_i(28, 2, 5, 14, OPI);      // srli
        img[14] = enc_i(32'h401, 2, 5, 15, OPI); // srai
        img[15] = enc_b(8, 2, 1, 1);             // bne x1,x2
        img[16] = enc_i(1, 0, 0, 16, OPI);
        img[17] = enc_b(8, 2, 1, 5);             // bge x1,x2
        img[18] = enc_i(2, 0, 0, 16, OPI);
        img[19] = enc_b(8, 2, 1, 6);             // bltu x1,x2
        img[20] = enc_i(3, 0, 0, 16, OPI);
        img[21] = 32'h0000_0073;
      end
    endcase
    for (int i = 0; i < 256; i++) dut.U_IM.ROM[i] = img[i];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_program(input int id);
    @(negedge clk);
    rstn = 1'b0;
    build_img(id);
    tick();
    rstn = 1'b1;
    cur_prog = id;
  endtask

  task automatic add(input int p, input logic [31:0] pc, input int k, input int i, input logic [31:0] v);
    vecs.push_back('{prog: p, pc: pc, kind: k, idx: i, val: v});
  endtask

  logic [31:0] exp_rf [0:31];

  initial begin
    // program 2: branches and jalr
    add(2, 32'h04, 0, 1, 32'h5);
    add(2, 32'h08, 0, 2, 32'hFFFFFFFD);
    add(2, 32'h10, 0, 13, 32'h0);
    add(2, 32'h18, 0, 13, 32'h0);
    add(2, 32'h1C, 0, 14, 32'h0);
    add(2, 32'h20, 0, 14, 32'h3);
    add(2, 32'h24, 3, 0, 32'h0);
    add(2, 32'h28, 3, 0, 32'h0);
    add(2, 32'h30, 0, 13, 32'h0);
    add(2, 32'h40, 0, 15, 32'h34);
    add(2, 32'h40, 0, 15, 32'h34);
    // program 4: remaining ALU ops and branches
    add(4, 32'h04, 0, 1, 32'h5);
    add(4, 32'h08, 0, 2, 32'hFFFFFFFD);
    add(4, 32'h0C, 0, 3, 32'h5);
    add(4, 32'h10, 0, 4, 32'hFFFFFFFD);
    add(4, 32'h14, 0, 5, 32'hFFFFFFF8);
    add(4, 32'h18, 0, 6, 32'h1);
    add(4, 32'h1C, 0, 7, 32'h0);
    add(4, 32'h20, 0, 8, 32'hA0);
    add(4, 32'h24, 0, 9, 32'h1);
    add(4, 32'h28, 0, 10, 32'h1);
    add(4, 32'h2C, 0, 11, 32'hF0);
    add(4, 32'h30, 0, 12, 32'hFFFFFFF5);
    add(4, 32'h34, 0, 13, 32'h50000000);
    add(4, 32'h38, 0, 14, 32'hF);
    add(4, 32'h3C, 0, 15, 32'hFFFFFFFE);
    add(4, 32'h44, 0, 16, 32'h0);
    add(4, 32'h4C, 0, 16, 32'h0);
    add(4, 32'h54, 0, 16, 32'h0);
    add(4, 32'h54, 3, 0, 32'h0);
    // program 3: unsupported encoding as NOP, ROM address wrap
    add(3, 32'h004, 0, 5, 32'h0);
    add(3, 32'h400, 0, 5, 32'h8);
    add(3, 32'h404, 2, 1, 32'h0);
    add(3, 32'h800, 0, 5, 32'h408);
    // program 1: main sequence, ends at ecall
    add(1, 32'h04, 0, 1, 32'h5);
    add(1, 32'h08, 0, 2, 32'hFFFFFFFD);
    add(1, 32'h0C, 0, 3, 32'h2);
    add(1, 32'h10, 0, 4, 32'hFFFFFFF8);
    add(1, 32'h14, 0, 5, 32'hFFFFFFFF);
    add(1, 32'h18, 0, 6, 32'h07FFFFFF);
    add(1, 32'h1C, 1, 2, 32'h2);
    add(1, 32'h20, 0, 7, 32'h2);
    add(1, 32'h2C, 0, 1, 32'h24);
    add(1, 32'h30, 0, 8, 32'h12345000);
    add(1, 32'h34, 0, 9, 32'h1030);
    add(1, 32'h38, 0, 0, 32'h0);
    add(1, 32'h3C, 0, 11, 32'hFFFFFFFF);
    add(1, 32'h40, 0, 12, 32'hFFFFFF0F);

    // reset asserted mid-cycle, then release
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("reset_pc", dut.PC, 32'h0);
    for (int r = 0; r < 32; r++) chk($sformatf("reset_rf[%0d]", r), dut.U_SCPU.U_RF.rf[r], 32'h0);
    build_img(2);
    tick();
    rstn = 1'b1;
    cur_prog = 2;
    chk("release_instr", dut.instr, img[0]);

    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].prog != cur_prog) load_program(vecs[v].prog);
      tick();
      chk($sformatf("v%0d_pc", v), dut.PC, vecs[v].pc);
      case (vecs[v].kind)
        0: chk($sformatf("v%0d_rf[%0d]", v, vecs[v].idx), dut.U_SCPU.U_RF.rf[vecs[v].idx], vecs[v].val);
        1: chk($sformatf("v%0d_dmem[%0d]", v, vecs[v].idx), dut.U_DM.dmem[vecs[v].idx], vecs[v].val);
        2: chk($sformatf("v%0d_instr", v), dut.instr, img[vecs[v].idx]);
        default: ;
      endcase
    end

    // halt: PC parked on ecall, architectural state frozen
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("halt_pc_c%0d", c), dut.PC, 32'h40);
    end
    for (int r = 0; r < 32; r++) exp_rf[r] = 32'h0;
    exp_rf[1] = 32'h24;       exp_rf[2] = 32'hFFFFFFFD; exp_rf[3] = 32'h2;
    exp_rf[4] = 32'hFFFFFFF8; exp_rf[5] = 32'hFFFFFFFF; exp_rf[6] = 32'h07FFFFFF;
    exp_rf[7] = 32'h2;        exp_rf[8] = 32'h12345000; exp_rf[9] = 32'h1030;
    exp_rf[11] = 32'hFFFFFFFF; exp_rf[12] = 32'hFFFFFF0F;
    for (int r = 0; r < 32; r++) chk($sformatf("halt_rf[%0d]", r), dut.U_SCPU.U_RF.rf[r], exp_rf[r]);
    for (int a = 0; a < 128; a++)
      chk($sformatf("halt_dmem[%0d]", a), dut.U_DM.dmem[a], (a == 2) ? 32'h2 : 32'h0);

    // reset in the middle of a running program
    load_program(1);
    for (int c = 0; c < 8; c++) tick();
    chk("mid_pc_before", dut.PC, 32'h20);
    chk("mid_x7_before", dut.U_SCPU.U_RF.rf[7], 32'h2);
    rstn = 1'b0;
    #1;
    chk("mid_pc_async", dut.PC, 32'h0);
    chk("mid_x1_async", dut.U_SCPU.U_RF.rf[1], 32'h0);
    chk("mid_x7_async", dut.U_SCPU.U_RF.rf[7], 32'h0);
    chk("mid_dmem_kept", dut.U_DM.dmem[2], 32'h2);
    @(negedge clk);
    tick();
    chk("mid_pc_held", dut.PC, 32'h0);
    chk("mid_x1_held", dut.U_SCPU.U_RF.rf[1], 32'h0);
    rstn = 1'b1;
    chk("mid_release_instr", dut.instr, img[0]);
    tick();
    chk("mid_restart_pc", dut.PC, 32'h4);
    chk("mid_restart_x1", dut.U_SCPU.U_RF.rf[1], 32'h5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
